// File: rtl/pmu_lockstep_cmp.sv
// rtl/pmu_lockstep_cmp.sv - staggered-lockstep primary/shadow channel comparator with fault FSM
// Optional PMU_LOCKSTEP_MASK_EN adds a per-channel mask_i input.
module pmu_lockstep_cmp #(
  parameter int N_CH       = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LAG        = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       main_valid_i,
  input  logic [N_CH*DATA_WIDTH-1:0] main_data_i,
  input  logic                       shadow_valid_i,
  input  logic [N_CH*DATA_WIDTH-1:0] shadow_data_i,
  input  logic                       clear_i,
  input  logic [CNT_WIDTH-1:0]       threshold_i,
`ifdef PMU_LOCKSTEP_MASK_EN
  input  logic [N_CH-1:0]            mask_i,
`endif
  output logic [N_CH-1:0]            mismatch_o,
  output logic                       desync_o,
  output logic [N_CH-1:0]            sticky_o,
  output logic [CNT_WIDTH-1:0]       err_cnt_o,
  output logic                       intr_o,
  output logic [1:0]                 state_o
);

  localparam int DW_ALL = N_CH * DATA_WIDTH;
  localparam logic [3:0] WARM_LAST = (LAG == 0) ? 4'd0 : 4'(LAG - 1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_CHECKING = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  state_t                state;
  logic [3:0]            warm_cnt;
  logic                  dly_valid;
  logic [DW_ALL-1:0]     dly_data;
  logic [N_CH-1:0]       ch_diff;
  logic [N_CH-1:0]       ch_mask;
  logic [N_CH-1:0]       mm;
  logic                  compare_cycle;
  logic                  desync;
  logic                  err_cycle;
  logic                  fault_hit;
  logic [CNT_WIDTH-1:0]  cnt_next;

  // Primary delay line; valid bits are flushed while disabled so stale samples never pair up.
  generate
    if (LAG == 0) begin : g_nodly
      assign dly_valid = main_valid_i;
      assign dly_data  = main_data_i;
    end else begin : g_dly
      logic [LAG-1:0]    vpipe;
      logic [DW_ALL-1:0] dpipe [LAG];

      always_ff @(posedge clk_i) begin
        if (rst_i || state == ST_DISABLED) begin
          vpipe <= '0;
        end else begin
          vpipe[0] <= main_valid_i;
          for (int i = 1; i < LAG; i++) vpipe[i] <= vpipe[i-1];
        end
        dpipe[0] <= main_data_i;
        for (int i = 1; i < LAG; i++) dpipe[i] <= dpipe[i-1];
      end

      assign dly_valid = vpipe[LAG-1];
      assign dly_data  = dpipe[LAG-1];
    end
  endgenerate

`ifdef PMU_LOCKSTEP_MASK_EN
  assign ch_mask = mask_i;
`else
  assign ch_mask = '0;
`endif

  always_comb begin
    ch_diff = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch_diff[k] = dly_data[k*DATA_WIDTH +: DATA_WIDTH] != shadow_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign compare_cycle = (state == ST_CHECKING || state == ST_FAULT) && (dly_valid || shadow_valid_i);
  assign mm            = (compare_cycle && dly_valid && shadow_valid_i) ? (ch_diff & ~ch_mask) : '0;
  assign desync        = compare_cycle && (dly_valid ^ shadow_valid_i);
  assign err_cycle     = (|mm) || desync;

  // Clear takes priority over an error in the same cycle.
  always_comb begin
    cnt_next = err_cnt_o;
    if (clear_i) begin
      cnt_next = '0;
    end else if (err_cycle && err_cnt_o != '1) begin
      cnt_next = err_cnt_o + 1'b1;
    end
  end

  assign fault_hit = compare_cycle && (threshold_i != '0) && (cnt_next >= threshold_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_DISABLED;
      warm_cnt   <= '0;
      mismatch_o <= '0;
      desync_o   <= 1'b0;
      sticky_o   <= '0;
      err_cnt_o  <= '0;
      intr_o     <= 1'b0;
    end else begin
      mismatch_o <= mm;
      desync_o   <= desync;
      err_cnt_o  <= cnt_next;
      sticky_o   <= clear_i ? '0 : (sticky_o | mm);
      intr_o     <= 1'b0;
      if (!enable_i) begin
        state <= ST_DISABLED;
      end else begin
        case (state)
          ST_DISABLED: begin
            state    <= ST_WARMUP;
            warm_cnt <= '0;
          end
          ST_WARMUP: begin
            if (warm_cnt == WARM_LAST) state <= ST_CHECKING;
            else warm_cnt <= warm_cnt + 4'd1;
          end
          ST_CHECKING: begin
            if (fault_hit) begin
              state  <= ST_FAULT;
              intr_o <= 1'b1;
            end
          end
          ST_FAULT: begin
            if (clear_i) state <= ST_CHECKING;
          end
          default: state <= ST_DISABLED;
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pmu_lockstep_cmp.sv
// tb/tb_pmu_lockstep_cmp.sv - scoreboard bench for pmu_lockstep_cmp (N_CH=4, DATA_WIDTH=8, LAG=2, CNT_WIDTH=4)
module tb_pmu_lockstep_cmp;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int LAG = 2;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            main_valid;
  logic [N*DW-1:0] main_data;
  logic            shadow_valid;
  logic [N*DW-1:0] shadow_data;
  logic            clear;
  logic [CW-1:0]   threshold;
  logic [N-1:0]    mismatch;
  logic            desync;
  logic [N-1:0]    sticky;
  logic [CW-1:0]   err_cnt;
  logic            intr;
  logic [1:0]      state;

  always #5 clk = ~clk;

  pmu_lockstep_cmp #(.N_CH(N), .DATA_WIDTH(DW), .LAG(LAG), .CNT_WIDTH(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .main_valid_i  (main_valid),
    .main_data_i   (main_data),
    .shadow_valid_i(shadow_valid),
    .shadow_data_i (shadow_data),
    .clear_i       (clear),
    .threshold_i   (threshold),
    .mismatch_o    (mismatch),
    .desync_o      (desync),
    .sticky_o      (sticky),
    .err_cnt_o     (err_cnt),
    .intr_o        (intr),
    .state_o       (state)
  );

  typedef struct packed { logic v; logic [N*DW-1:0] d; } samp_t;
  typedef struct packed { logic [N-1:0] mm; logic ds; } exp_t;

  samp_t mq[$];
  exp_t  eq[$];
  int    errors = 0;
  int    checks = 0;
  int    intr_cnt = 0;
  int    m_state = 0;  // 0 disabled, 1 warmup, 2 comparing
  int    m_w = 0;
  logic  hv0 = 1'b0, hv1 = 1'b0;
  logic [N*DW-1:0] hd0 = '0, hd1 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle; the expected compare result is queued now and popped once the edge has produced it.
  task automatic step(input logic mv, input logic [N*DW-1:0] md, input logic sv, input logic [N*DW-1:0] sd);
    samp_t pm;
    exp_t  e;
    bit    pipe_on, cmp_on;
    pipe_on = !rst && m_state != 0;
    cmp_on  = !rst && m_state == 2;
    main_valid   = mv;
    main_data    = md;
    shadow_valid = sv;
    shadow_data  = sd;
    pm = '0;
    if (pipe_on) begin
      mq.push_back(samp_t'{v: mv, d: md});
      while (mq.size() > LAG) pm = mq.pop_front();
    end else begin
      mq.delete();
    end
    e = '0;
    if (cmp_on && (pm.v || sv)) begin
      for (int k = 0; k < N; k++)
        if (pm.v && sv && pm.d[k*DW +: DW] != sd[k*DW +: DW]) e.mm[k] = 1'b1;
      e.ds = pm.v ^ sv;
    end
    eq.push_back(e);
    if (rst || !enable) m_state = 0;
    else if (m_state == 0) begin m_state = 1; m_w = 0; end
    else if (m_state == 1) begin
      if (m_w == LAG - 1) m_state = 2;
      else m_w++;
    end
    @(posedge clk);
    #1;
    if (intr) intr_cnt++;
    e = eq.pop_front();
    check("mismatch_sb", {28'd0, mismatch}, {28'd0, e.mm});
    check("desync_sb", {31'd0, desync}, {31'd0, e.ds});
  endtask

  // Shadow replays the primary from LAG steps earlier, optionally corrupted or with its valid dropped.
  task automatic sync_step(input logic [N*DW-1:0] md, input logic [N-1:0] corrupt, input logic drop_sv);
    logic [N*DW-1:0] sd;
    sd = hd1;
    for (int k = 0; k < N; k++)
      if (corrupt[k]) sd[k*DW +: DW] = sd[k*DW +: DW] ^ 8'hFF;
    step(1'b1, md, hv1 & ~drop_sv, sd);
    hv1 = hv0; hd1 = hd0;
    hv0 = 1'b1; hd0 = md;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [N*DW-1:0] md;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; threshold = '0;
    main_valid = 1'b0; main_data = '0; shadow_valid = 1'b0; shadow_data = '0;
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    check("rst_state", state, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_sticky", sticky, 0);
    check("rst_intr", intr, 0);

    // 1: warmup sequence and clean lockstep
    rst = 1'b0; enable = 1'b1;
    sync_step($urandom, '0, 1'b0); check("warm_st1", state, 1);
    sync_step($urandom, '0, 1'b0); check("warm_st2", state, 1);
    sync_step($urandom, '0, 1'b0); check("warm_st3", state, 2);
    for (int i = 0; i < 8; i++) sync_step($urandom, '0, 1'b0);
    check("clean_cnt", err_cnt, 0);
    check("clean_intr", intr_cnt, 0);

    // 2: single channel mismatch, threshold 0
    md = $urandom; md[23:16] = 8'h5A;
    sync_step(md, '0, 1'b0);
    sync_step($urandom, '0, 1'b0);
    sync_step($urandom, 4'b0100, 1'b0);
    check("ch2_mm", mismatch, 4'b0100);
    check("ch2_sticky", sticky, 4'b0100);
    check("ch2_cnt", err_cnt, 1);
    check("ch2_state", state, 2);

    // 3: threshold fault, post-fault counting, clear back to checking
    clear = 1'b1; sync_step($urandom, '0, 1'b0); clear = 1'b0;
    check("clr_cnt", err_cnt, 0);
    check("clr_sticky", sticky, 0);
    threshold = 4'd3;
    sync_step($urandom, 4'b0001, 1'b0);
    sync_step($urandom, 4'b0001, 1'b0);
    check("thr_pre_intr", intr, 0);
    sync_step($urandom, 4'b0001, 1'b0);
    check("thr_cnt", err_cnt, 3);
    check("thr_intr", intr, 1);
    check("thr_state", state, 3);
    sync_step($urandom, '0, 1'b0);
    check("thr_intr_once", intr, 0);
    sync_step($urandom, 4'b0001, 1'b0);
    check("fault_cnt", err_cnt, 4);
    check("fault_intr", intr, 0);
    check("fault_state", state, 3);
    clear = 1'b1; sync_step($urandom, '0, 1'b0); clear = 1'b0;
    check("fclr_cnt", err_cnt, 0);
    check("fclr_sticky", sticky, 0);
    check("fclr_state", state, 2);
    threshold = '0;

    // 4: saturation
    for (int i = 0; i < 20; i++) sync_step($urandom, 4'b1000, 1'b0);
    check("sat_cnt", err_cnt, 15);
    check("sat_state", state, 2);
    clear = 1'b1; sync_step($urandom, '0, 1'b0); clear = 1'b0;

    // 5: desync
    sync_step($urandom, '0, 1'b1);
    check("desync", desync, 1);
    check("desync_mm", mismatch, 0);
    check("desync_cnt", err_cnt, 1);

    // 6: clear wins over a coincident error, then disable/re-enable
    clear = 1'b1; sync_step($urandom, 4'b0010, 1'b0); clear = 1'b0;
    check("clrwin_mm", mismatch, 4'b0010);
    check("clrwin_cnt", err_cnt, 0);
    check("clrwin_sticky", sticky, 0);
    sync_step($urandom, 4'b0001, 1'b0);
    check("pre_dis_cnt", err_cnt, 1);
    enable = 1'b0;
    sync_step($urandom, '0, 1'b0);
    check("dis_state", state, 0);
    sync_step($urandom, '0, 1'b0);
    sync_step($urandom, '0, 1'b0);
    check("dis_hold_cnt", err_cnt, 1);
    check("dis_hold_sticky", sticky, 4'b0001);
    enable = 1'b1;
    sync_step($urandom, '0, 1'b0); check("re_st1", state, 1);
    sync_step($urandom, '0, 1'b0); check("re_st2", state, 1);
    sync_step($urandom, '0, 1'b0); check("re_st3", state, 2);
    for (int i = 0; i < 4; i++) sync_step($urandom, '0, 1'b0);
    check("re_cnt", err_cnt, 1);

    enable = 1'b0; clear = 1'b1;
    sync_step($urandom, '0, 1'b0);
    clear = 1'b0;
    check("dis_clr_state", state, 0);
    check("dis_clr_cnt", err_cnt, 0);
    check("dis_clr_sticky", sticky, 0);
    check("intr_total", intr_cnt, 1);
    check("sb_empty", eq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pmu_lockstep_cmp.md
Name: pmu_lockstep_cmp

Overview:
Runtime, parametrised successor to the PMU FT/non-FT equivalence check. The formal check compared two PMU instances offline. This block compares N_CH output channels of a primary instance against a redundant shadow instance in silicon. The shadow may run LAG cycles behind the primary (staggered lockstep). Mismatches are recorded per channel, counted, and raised as an interrupt to the SafeSU interrupt path once a programmable threshold is reached.

Parameters:
N_CH, 8, number of compared channels (1..32)
DATA_WIDTH, 32, width of each channel
LAG, 2, shadow delay in cycles (0..15); primary is delayed LAG cycles before compare
CNT_WIDTH, 16, mismatch counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  comparison enable
main_valid_i  in  1  primary channels valid this cycle
main_data_i  in  N_CH*DATA_WIDTH  primary channels, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
shadow_valid_i  in  1  shadow channels valid this cycle
shadow_data_i  in  N_CH*DATA_WIDTH  shadow channels, same packing
clear_i  in  1  clears sticky flags and counter, and leaves FAULT
threshold_i  in  CNT_WIDTH  fault threshold; 0 = never fault
mismatch_o  out  N_CH  per-channel mismatch of the last compare (registered)
desync_o  out  1  last compare had exactly one valid asserted (registered)
sticky_o  out  N_CH  accumulated per-channel mismatch
err_cnt_o  out  CNT_WIDTH  saturating count of mismatching compare cycles
intr_o  out  1  single-cycle fault pulse
state_o  out  2  FSM state: 0 DISABLED, 1 WARMUP, 2 CHECKING, 3 FAULT

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge): all outputs 0, state DISABLED, delay pipeline valid bits cleared. Reset mid-operation discards in-flight data.
- Delay line: LAG-stage register pipeline of {main_valid_i, main_data_i}. LAG=0 means a direct connection. Delayed valid bits are cleared whenever state is DISABLED.
- Compare cycle: state CHECKING or FAULT, and delayed main valid or shadow_valid_i is 1.
  - Channel k mismatches when both valids are 1 and the data differ.
  - Desync occurs when exactly one of the two valids is 1.
  - A cycle is erroneous if any channel mismatches or a desync occurs.
- Latency: primary sample at cycle t pairs with shadow at t+LAG; the result is visible on mismatch_o/desync_o at t+LAG+1.
- mismatch_o/desync_o: updated each cycle. Forced to 0 on non-compare cycles.
- sticky_o: ORs in mismatch bits. err_cnt_o: +1 per erroneous cycle, saturates at all-ones and never wraps.
- FSM:
  - DISABLED -> WARMUP when enable_i=1.
  - WARMUP counts LAG cycles (a 4-bit counter), then -> CHECKING. With LAG=0, goes straight to CHECKING on the next edge.
  - CHECKING -> FAULT when threshold_i!=0 and the updated count >= threshold_i. intr_o=1 for exactly that one cycle.
  - FAULT: keeps counting and updating sticky. No further intr_o.
  - FAULT -> CHECKING on clear_i.
  - Any state -> DISABLED when enable_i=0. Count and sticky are held.
- clear_i: zeroes err_cnt_o and sticky_o.
  - If clear_i coincides with an erroneous cycle, clear wins: that cycle is not counted and sets no sticky bit.
  - mismatch_o still reflects the cycle.
- Threshold raised or lowered while in CHECKING: applies from the next compare.
- Simultaneous enable_i=0 and clear_i: both take effect.

Optional Feature:
PMU_LOCKSTEP_MASK_EN
- Defined: adds input mask_i [N_CH]. A channel with mask_i[k]=1 never mismatches and is excluded from the erroneous-cycle decision. Desync is not maskable.
- Undefined: no mask_i port; all channels are compared.

Test Plan:
Config for all scenarios: N_CH=4, DATA_WIDTH=8, LAG=2, CNT_WIDTH=4.
1. Reset then enable_i=1 → state_o goes 0→1 (two cycles)→2; identical streams with both valids → mismatch_o=0, err_cnt_o=0, intr_o never set.
2. Primary ch2=0x5A at t, shadow ch2=0xA5 at t+2, threshold_i=0 → at t+3 mismatch_o=4'b0100, sticky_o=4'b0100, err_cnt_o=1, state stays 2.
3. threshold_i=3, three erroneous cycles → err_cnt_o=3, intr_o high for one cycle, state_o=3. Fourth error → err_cnt_o=4, no intr. clear_i → err_cnt_o=0, sticky_o=0, state_o=2.
4. 20 consecutive erroneous cycles with threshold_i=0 → err_cnt_o saturates at 15.
5. main_valid_i=1 at t with shadow_valid_i=0 at t+2 → desync_o=1 at t+3, err_cnt_o=1, mismatch_o=0.
6. clear_i asserted in the same cycle as a mismatching compare → err_cnt_o=0, sticky_o=0. enable_i=0 mid-stream → state_o=0, pipeline flushed, counter held. Re-enable → two WARMUP cycles before compares resume.
